// File: rtl/uni_arb_if.sv
// uni_if: valid/ready request bundle shared by the fetch unit, the load/store unit and the AXI bridge.
// Data width comes from the CPU_WIDTH macro (default 32).
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface uni_if;
    logic                    valid;
    logic                    reqtyp;
    logic [`CPU_WIDTH-1:0]   addr;
    logic [`CPU_WIDTH-1:0]   wdata;
    logic [1:0]              size;
    logic                    ready;
    logic [`CPU_WIDTH-1:0]   rdata;

    modport Master (output valid, reqtyp, addr, wdata, size, input  ready, rdata);
    modport Slave  (input  valid, reqtyp, addr, wdata, size, output ready, rdata);
endinterface

// File: rtl/uni_arb.sv
// uni_arb: 2:1 arbiter sharing one downstream uni_if port between IFU and LSU, with grant watchdog.
// Define UNI_ARB_RR_EN for round-robin tie-breaking; default is fixed LSU priority.
module uni_arb #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    uni_if.Slave        UniIf_IFU,
    uni_if.Slave        UniIf_LSU,
    uni_if.Master       UniIf_M,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int unsigned WDOG_W = 10;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_G_IFU = 2'b01;
    localparam logic [1:0] S_G_LSU = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] w_wdog_nxt;
    logic              r_timeout;
    logic              w_m_valid;
    logic              w_hs;
    logic              w_ifu_wins_tie;

`ifdef UNI_ARB_RR_EN
    // Last-grant pointer: 0 = IFU, 1 = LSU; the other side wins the next tie.
    logic r_last_lsu;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_lsu <= 1'b0;
        end else if ((r_state == S_IDLE) && (w_state_nxt != S_IDLE)) begin
            r_last_lsu <= (w_state_nxt == S_G_LSU);
        end
    end

    assign w_ifu_wins_tie = r_last_lsu;
`else
    assign w_ifu_wins_tie = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: grant from IDLE only, always return to IDLE after a handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (UniIf_IFU.valid && UniIf_LSU.valid) begin
                    w_state_nxt = w_ifu_wins_tie ? S_G_IFU : S_G_LSU;
                end else if (UniIf_IFU.valid) begin
                    w_state_nxt = S_G_IFU;
                end else if (UniIf_LSU.valid) begin
                    w_state_nxt = S_G_LSU;
                end
            end
            S_G_IFU, S_G_LSU: begin
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Routing: downstream fields from the granted requester, ready/rdata back to it only
    always_comb begin
        UniIf_M.valid   = 1'b0;
        UniIf_M.reqtyp  = 1'b0;
        UniIf_M.addr    = '0;
        UniIf_M.wdata   = '0;
        UniIf_M.size    = 2'b00;
        UniIf_IFU.ready = 1'b0;
        UniIf_IFU.rdata = '0;
        UniIf_LSU.ready = 1'b0;
        UniIf_LSU.rdata = '0;
        case (r_state)
            S_G_IFU: begin
                UniIf_M.valid   = UniIf_IFU.valid;
                UniIf_M.reqtyp  = UniIf_IFU.reqtyp;
                UniIf_M.addr    = UniIf_IFU.addr;
                UniIf_M.wdata   = UniIf_IFU.wdata;
                UniIf_M.size    = UniIf_IFU.size;
                UniIf_IFU.ready = UniIf_M.ready;
                UniIf_IFU.rdata = UniIf_M.rdata;
            end
            S_G_LSU: begin
                UniIf_M.valid   = UniIf_LSU.valid;
                UniIf_M.reqtyp  = UniIf_LSU.reqtyp;
                UniIf_M.addr    = UniIf_LSU.addr;
                UniIf_M.wdata   = UniIf_LSU.wdata;
                UniIf_M.size    = UniIf_LSU.size;
                UniIf_LSU.ready = UniIf_M.ready;
                UniIf_LSU.rdata = UniIf_M.rdata;
            end
            default: ;
        endcase
    end

    assign w_m_valid = ((r_state == S_G_IFU) && UniIf_IFU.valid) ||
                       ((r_state == S_G_LSU) && UniIf_LSU.valid);
    assign w_hs      = w_m_valid && UniIf_M.ready;

    // Watchdog: counts stalled grant cycles, saturating at TIMEOUT_CYC
    always_comb begin
        w_wdog_nxt = r_wdog;
        if ((r_state == S_IDLE) || w_hs) begin
            w_wdog_nxt = '0;
        end else if (r_wdog != WDOG_W'(TIMEOUT_CYC)) begin
            w_wdog_nxt = r_wdog + WDOG_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog    <= w_wdog_nxt;
            r_timeout <= r_timeout | (w_wdog_nxt == WDOG_W'(TIMEOUT_CYC));
        end
    end

    assign o_grant   = r_state;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_uni_arb.sv
// Directed self-checking bench for uni_arb (TIMEOUT_CYC = 8).
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_uni_arb;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [1:0] o_grant;
    logic       o_timeout;

    uni_if u_ifu ();
    uni_if u_lsu ();
    uni_if u_m ();

    uni_arb #(.TIMEOUT_CYC(8)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .UniIf_IFU (u_ifu),
        .UniIf_LSU (u_lsu),
        .UniIf_M   (u_m),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_IFU  = 2'b01;
    localparam logic [1:0] G_LSU  = 2'b10;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;

        i_rst = 1'b1;
        u_ifu.valid = 0; u_ifu.reqtyp = 0; u_ifu.addr = 0; u_ifu.wdata = 0; u_ifu.size = 0;
        u_lsu.valid = 0; u_lsu.reqtyp = 0; u_lsu.addr = 0; u_lsu.wdata = 0; u_lsu.size = 0;
        u_m.ready = 0; u_m.rdata = 0;
        step();
        step();
        i_rst = 1'b0;
        #1;
        chk("rst_grant",   32'(o_grant),   32'(G_NONE));
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_m_valid", 32'(u_m.valid), 32'd0);
        chk("rst_m_addr",  u_m.addr,       32'd0);

        // IFU alone, ready on the third grant cycle
        u_ifu.valid = 1; u_ifu.addr = 32'h8000_0000; u_ifu.size = 2'b10;
        #1;
        chk("t1_idle_m_valid", 32'(u_m.valid), 32'd0);
        step(); #1;
        chk("t1_grant",   32'(o_grant),   32'(G_IFU));
        chk("t1_m_valid", 32'(u_m.valid), 32'd1);
        chk("t1_m_addr",  u_m.addr,       32'h8000_0000);
        step(); #1;
        chk("t1_ifu_rdy_early", 32'(u_ifu.ready), 32'd0);
        step();
        u_m.ready = 1; u_m.rdata = 32'h0000_0013;
        #1;
        chk("t1_ifu_rdy",   32'(u_ifu.ready), 32'd1);
        chk("t1_ifu_rdata", u_ifu.rdata,      32'h0000_0013);
        chk("t1_lsu_rdy",   32'(u_lsu.ready), 32'd0);
        chk("t1_lsu_rdata", u_lsu.rdata,      32'd0);
        step();
        u_ifu.valid = 0; u_m.ready = 0; u_m.rdata = 0;
        #1;
        chk("t1_grant_done", 32'(o_grant),   32'(G_NONE));
        chk("t1_m_idle",     32'(u_m.valid), 32'd0);

        // LSU store while IFU idle
        u_lsu.valid = 1; u_lsu.reqtyp = 1; u_lsu.addr = 32'h8000_1000;
        u_lsu.wdata = 32'hDEAD_BEEF; u_lsu.size = 2'b10;
        step(); #1;
        chk("t2_grant",    32'(o_grant),    32'(G_LSU));
        chk("t2_m_reqtyp", 32'(u_m.reqtyp), 32'd1);
        chk("t2_m_addr",   u_m.addr,        32'h8000_1000);
        chk("t2_m_wdata",  u_m.wdata,       32'hDEAD_BEEF);
        chk("t2_m_size",   32'(u_m.size),   32'd2);
        u_m.ready = 1; u_m.rdata = 32'h0000_0055;
        #1;
        chk("t2_lsu_rdy",   32'(u_lsu.ready), 32'd1);
        chk("t2_ifu_rdy",   32'(u_ifu.ready), 32'd0);
        chk("t2_ifu_rdata", u_ifu.rdata,      32'd0);
        step();
        u_lsu.valid = 0; u_lsu.reqtyp = 0; u_m.ready = 0; u_m.rdata = 0;
        #1;
        chk("t2_grant_done", 32'(o_grant), 32'(G_NONE));

        // Simultaneous requests held continuously for four rounds
        u_ifu.valid = 1; u_ifu.addr = 32'h0000_1111;
        u_lsu.valid = 1; u_lsu.addr = 32'h0000_2222;
        for (int r = 0; r < 4; r++) begin
`ifdef UNI_ARB_RR_EN
            exp_g = (r % 2 == 0) ? G_LSU : G_IFU;
`else
            exp_g = G_LSU;
`endif
            step();
            u_m.ready = 1; u_m.rdata = 32'h100 + 32'(r);
            #1;
            chk("t3_grant", 32'(o_grant), 32'(exp_g));
            chk("t3_m_addr", u_m.addr, (exp_g == G_IFU) ? 32'h0000_1111 : 32'h0000_2222);
            chk("t3_ifu_rdy", 32'(u_ifu.ready), (exp_g == G_IFU) ? 32'd1 : 32'd0);
            chk("t3_lsu_rdy", 32'(u_lsu.ready), (exp_g == G_LSU) ? 32'd1 : 32'd0);
            step();
            u_m.ready = 0; u_m.rdata = 0;
            #1;
            chk("t3_idle", 32'(o_grant), 32'(G_NONE));
        end
        u_ifu.valid = 0; u_lsu.valid = 0;
        step();

        // LSU arrives while IFU holds the grant
        u_ifu.addr = 32'h8000_0040;
        step(); #1;
        chk("t4_grant_ifu", 32'(o_grant), 32'(G_NONE));
        u_ifu.valid = 1;
        step();
        u_lsu.valid = 1; u_lsu.addr = 32'h8000_2000;
        #1;
        chk("t4_grant_ifu", 32'(o_grant), 32'(G_IFU));
        step(); #1;
        chk("t4_hold_ifu",  32'(o_grant),     32'(G_IFU));
        chk("t4_m_addr",    u_m.addr,         32'h8000_0040);
        chk("t4_lsu_wait",  32'(u_lsu.ready), 32'd0);
        u_m.ready = 1;
        #1;
        chk("t4_ifu_rdy", 32'(u_ifu.ready), 32'd1);
        step();
        u_ifu.valid = 0; u_m.ready = 0;
        #1;
        chk("t4_idle", 32'(o_grant), 32'(G_NONE));
        step(); #1;
        chk("t4_grant_lsu", 32'(o_grant), 32'(G_LSU));
        chk("t4_m_addr2",   u_m.addr,     32'h8000_2000);
        u_m.ready = 1;
        step();
        u_lsu.valid = 0; u_m.ready = 0;
        step();

        // Watchdog: no downstream response
        u_ifu.valid = 1; u_ifu.addr = 32'h8000_0080;
        step(); #1;
        chk("t5_grant", 32'(o_grant), 32'(G_IFU));
        for (int i = 1; i <= 8; i++) begin
            chk("t5_no_timeout", 32'(o_timeout), 32'd0);
            step(); #1;
        end
        chk("t5_timeout_set", 32'(o_timeout), 32'd1);
        step(); #1;
        chk("t5_timeout_sticky", 32'(o_timeout), 32'd1);
        chk("t5_grant_held",     32'(o_grant),   32'(G_IFU));
        u_m.ready = 1;
        #1;
        chk("t5_late_rdy", 32'(u_ifu.ready), 32'd1);
        step();
        u_ifu.valid = 0; u_m.ready = 0;
        #1;
        chk("t5_after_hs_timeout", 32'(o_timeout), 32'd1);
        chk("t5_after_hs_grant",   32'(o_grant),   32'(G_NONE));

        // Reset during G_LSU
        u_lsu.valid = 1; u_lsu.addr = 32'h8000_3000;
        step(); #1;
        chk("t6_grant_lsu", 32'(o_grant), 32'(G_LSU));
        i_rst = 1;
        step();
        i_rst = 0; u_lsu.valid = 0;
        #1;
        chk("t6_rst_grant",   32'(o_grant),   32'(G_NONE));
        chk("t6_rst_m_valid", 32'(u_m.valid), 32'd0);
        chk("t6_rst_timeout", 32'(o_timeout), 32'd0);
        u_ifu.valid = 1; u_ifu.addr = 32'h8000_0100;
        step(); #1;
        chk("t6_fresh_grant", 32'(o_grant),   32'(G_IFU));
        chk("t6_fresh_valid", 32'(u_m.valid), 32'd1);
        u_m.ready = 1;
        step();
        u_ifu.valid = 0; u_m.ready = 0;
        #1;
        chk("t6_fresh_done", 32'(o_grant), 32'(G_NONE));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
